// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle MUL/SMUL/UMUL/DIV controller with a
// 1-bit-per-cycle shift-add multiplier and a restoring divider, followed by
// one (32-bit result) or two (lo, hi) writeback phases.
// Optional build macro: MULDIV_EARLY_TERM_EN lets multiplies leave CALC as
// soon as the remaining multiplier magnitude is zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             wb_ready,
  output logic             busy,
  output logic [WIDTH-1:0] ResultW,
  output logic             ResultWE,
  output logic             ResultHi,
  output logic             longFlag,
  output logic             DivZero
);

  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

  localparam logic [2:0]       OP_SMUL  = 3'b101;
  localparam logic [2:0]       OP_UMUL  = 3'b110;
  localparam logic [2:0]       OP_DIV   = 3'b111;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_q, state_d;
  // Multiply: acc = running product, mcand = left-shifting multiplicand,
  // mplier = right-shifting multiplier. Divide: acc = {remainder, dividend
  // shifting into quotient}, mcand[WIDTH-1:0] = divisor.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 long_q, long_d;
  logic                 divzero_q, divzero_d;

  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]     mul_mplier;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_acc;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 calc_done;

  // One datapath iteration for each operation, plus operand magnitudes for SMUL.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    mul_acc    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_mplier = mplier_q >> 1;
    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, mcand_q[WIDTH-1:0]};
    // When the trial subtraction succeeds the difference is below the divisor,
    // so it fits in WIDTH bits and the modulo subtraction is exact.
    div_rem    = div_ge ? (div_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0])
                        : div_shift[WIDTH-1:0];
    div_acc    = {div_rem, acc_q[WIDTH-2:0], div_ge};
    mag_a      = (ALUControl == OP_SMUL && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b      = (ALUControl == OP_SMUL && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  end

  // Next-state and register-update logic for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    long_d    = long_q;
    divzero_d = divzero_q;
    calc_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Codes 100..111 are the only valid ones; anything else is ignored.
        if (start && ALUControl[2]) begin
          long_d    = (ALUControl == OP_SMUL) || (ALUControl == OP_UMUL);
          is_div_d  = (ALUControl == OP_DIV);
          neg_d     = (ALUControl == OP_SMUL) && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          cnt_d     = CNT_INIT;
          divzero_d = 1'b0;
          mplier_d  = mag_b;
          if (ALUControl == OP_DIV) begin
            mcand_d = {{WIDTH{1'b0}}, SrcB};
            if (SrcB == '0) begin
              divzero_d = 1'b1;
              acc_d     = {SrcA, {WIDTH{1'b1}}};
              state_d   = WB_LO;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, SrcA};
              state_d = CALC;
            end
          end else begin
            mcand_d = {{WIDTH{1'b0}}, mag_a};
            acc_d   = '0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (is_div_q) begin
          acc_d     = div_acc;
          calc_done = (cnt_q == CNT_ONE);
        end else begin
          acc_d    = mul_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mul_mplier;
`ifdef MULDIV_EARLY_TERM_EN
          // The multiplicand is shifted, not the accumulator, so the product
          // is already in final alignment whenever the multiplier runs out.
          calc_done = (cnt_q == CNT_ONE) || (mul_mplier == '0);
`else
          calc_done = (cnt_q == CNT_ONE);
`endif
          if (calc_done && neg_q) begin
            acc_d = -mul_acc;
          end
        end
        if (calc_done) begin
          cnt_d   = '0;
          state_d = WB_LO;
        end
      end

      WB_LO: begin
        if (wb_ready) begin
          state_d = long_q ? WB_HI : IDLE;
        end
      end

      WB_HI: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and flag registers; reset aborts any running operation.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      long_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      long_q    <= long_d;
      divzero_q <= divzero_d;
    end
  end

  // Writeback and status outputs decoded from the current state.
  always_comb begin
    busy     = (state_q != IDLE);
    ResultWE = (state_q == WB_LO) || (state_q == WB_HI);
    ResultHi = (state_q == WB_HI);
    ResultW  = '0;
    if (state_q == WB_LO) ResultW = acc_q[WIDTH-1:0];
    if (state_q == WB_HI) ResultW = acc_q[2*WIDTH-1:WIDTH];
    longFlag = long_q;
    DivZero  = divzero_q;
  end

endmodule
